// File: rtl/sr_latch_sequencer_if.sv
// Requester-side handshake bundle for sr_latch_sequencer: level requests and
// target values in; one-hot grant, busy and done/err pulses out.
interface sr_latch_sequencer_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_val;
  logic [N_REQ-1:0] gnt;
  logic             busy;
  logic             done;
  logic             err;

  modport master (output req, req_val, input gnt, busy, done, err);
  modport slave  (input req, req_val, output gnt, busy, done, err);
endinterface

// File: rtl/sr_latch_sequencer.sv
// Round-robin sequencer sharing one NAND SR latch: timed active-low set/reset
// pulse, settle window, then readback of the 2-flop synchronized Q/Qbar.
module sr_latch_sequencer #(
  parameter int N_REQ      = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 3,
  parameter int CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sr_latch_sequencer_if.slave  bus,
  input  logic                 q_in,
  input  logic                 qbar_in,
  output logic                 sbar,
  output logic                 rbar,
  output logic                 q_state
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, PULSE, SETTLE, CHECK, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              val_q, val_d;
  logic              sbar_q, sbar_d, rbar_q, rbar_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]        qsync_q, qsync_d, qbsync_q, qbsync_d;

  logic              win_any;
  logic [PW-1:0]     win_idx;

  // Scan from the highest offset down so the lowest offset from ptr_q wins.
  always_comb begin
    int idx;
    idx     = 0;
    win_any = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (bus.req[idx]) begin
        win_any = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    val_d    = val_q;
    sbar_d   = sbar_q;
    rbar_d   = rbar_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    qsync_d  = {qsync_q[0], q_in};
    qbsync_d = {qbsync_q[0], qbar_in};
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        gnt_d   = '0;
        sbar_d  = 1'b1;
        rbar_d  = 1'b1;
        if (win_any) begin
          state_d        = PULSE;
          gnt_d[win_idx] = 1'b1;
          val_d          = bus.req_val[win_idx];
          cnt_d          = CNT_W'(PULSE_CYC - 1);
          ptr_d          = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          // Exactly one input goes low, so sbar=rbar=0 can never be registered.
          sbar_d         = ~bus.req_val[win_idx];
          rbar_d         = bus.req_val[win_idx];
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
          sbar_d  = 1'b1;
          rbar_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      CHECK: begin
        state_d = RESP;
        done_d  = 1'b1;
        err_d   = (qsync_q[1] != val_q) || (qbsync_q[1] != ~val_q);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      val_q    <= 1'b0;
      sbar_q   <= 1'b1;
      rbar_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      qsync_q  <= '0;
      qbsync_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      val_q    <= val_d;
      sbar_q   <= sbar_d;
      rbar_q   <= rbar_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      qsync_q  <= qsync_d;
      qbsync_q <= qbsync_d;
    end
  end

  assign sbar     = sbar_q;
  assign rbar     = rbar_q;
  assign q_state  = qsync_q[1];
  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule
